// File: rtl/mac_vector_engine.sv
`default_nettype none
// ============================================================================
// Module   : mac_vector_engine
// Brief    : Pipelined signed multiply-accumulate engine (dot product or
//            single multiply-add) with valid/ready streams and saturation.
// Revision : 1.0
// ============================================================================
module mac_vector_engine #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 25,
    parameter int CNT_W    = 8,
    parameter int SATURATE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic signed [DATA_W-1:0] in_b,
    input  logic signed [DATA_W-1:0] in_add,
    input  logic                     in_last,
    input  logic                     in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_sat,
    output logic                     out_cnt_ovf
);

    generate
        if (ACC_W < 2 * DATA_W + 1) begin : g_acc_w_check
            $error("mac_vector_engine: ACC_W must be at least 2*DATA_W+1");
        end
    endgenerate

    localparam int                      c_prod_w  = 2 * DATA_W;
    localparam logic [CNT_W-1:0]        c_cnt_max = '1;
    localparam logic [CNT_W-1:0]        c_cnt_one = CNT_W'(1);
    localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_vec_mode;
    logic   w_vec_mode_next;

    logic w_en;
    logic w_accept;
    logic w_first;
    logic w_last;
    logic w_mode_eff;

    logic signed [c_prod_w-1:0] w_a_ext;
    logic signed [c_prod_w-1:0] w_b_ext;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_add_ext;

    logic                       r_p_valid;
    logic                       r_p_first;
    logic                       r_p_last;
    logic signed [c_prod_w-1:0] r_p_prod;
    logic signed [ACC_W-1:0]    r_p_addend;

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_sat;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_cnt_ovf;

    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W:0]   w_sum;
    logic                    w_ovf;
    logic signed [ACC_W-1:0] w_acc_next;
    logic                    w_sat_next;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_cnt_ovf_next;

    // The whole pipeline freezes only while a result is held back by the consumer.
    assign w_en     = !(out_valid && !out_ready);
    assign in_ready = w_en && reset;
    assign w_accept = in_valid && in_ready;

    assign w_a_ext   = {{DATA_W{in_a[DATA_W-1]}}, in_a};
    assign w_b_ext   = {{DATA_W{in_b[DATA_W-1]}}, in_b};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_add_ext = {{(ACC_W-DATA_W){in_add[DATA_W-1]}}, in_add};

    // Framing: mode is taken from the beat that opens a vector, then held.
    always_comb begin
        w_first         = (r_state == ST_IDLE);
        w_mode_eff      = w_first ? in_mode : r_vec_mode;
        w_last          = in_last || !w_mode_eff;
        w_state_next    = r_state;
        w_vec_mode_next = r_vec_mode;
        if (w_accept) begin
            if (w_first) begin
                w_vec_mode_next = in_mode;
            end
            w_state_next = w_last ? ST_IDLE : ST_OPEN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_vec_mode <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_vec_mode <= w_vec_mode_next;
        end
    end

    always_comb begin
        w_base = r_p_first ? r_p_addend : r_acc;
        w_sum  = {w_base[ACC_W-1], w_base}
               + {{(ACC_W+1-c_prod_w){r_p_prod[c_prod_w-1]}}, r_p_prod};
        w_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];

        w_acc_next = w_sum[ACC_W-1:0];
        if (w_ovf && (SATURATE != 0)) begin
            w_acc_next = w_sum[ACC_W] ? c_acc_min : c_acc_max;
        end
        w_sat_next = (r_p_first ? 1'b0 : r_sat) || w_ovf;

        w_cnt_next     = r_cnt + c_cnt_one;
        w_cnt_ovf_next = r_cnt_ovf;
        if (r_p_first) begin
            w_cnt_next     = c_cnt_one;
            w_cnt_ovf_next = 1'b0;
        end else if (r_cnt == c_cnt_max) begin
            w_cnt_next     = r_cnt;
            w_cnt_ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p_valid   <= 1'b0;
            r_p_first   <= 1'b0;
            r_p_last    <= 1'b0;
            r_p_prod    <= '0;
            r_p_addend  <= '0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_cnt       <= '0;
            r_cnt_ovf   <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_count   <= '0;
            out_sat     <= 1'b0;
            out_cnt_ovf <= 1'b0;
        end else if (w_en) begin
            r_p_valid <= w_accept;
            if (w_accept) begin
                r_p_first  <= w_first;
                r_p_last   <= w_last;
                r_p_prod   <= w_prod;
                r_p_addend <= w_add_ext;
            end
            if (r_p_valid) begin
                r_acc     <= w_acc_next;
                r_sat     <= w_sat_next;
                r_cnt     <= w_cnt_next;
                r_cnt_ovf <= w_cnt_ovf_next;
            end
            // With en high any held result is being taken, so a new load simply replaces it.
            out_valid <= r_p_valid && r_p_last;
            if (r_p_valid && r_p_last) begin
                out_data    <= w_acc_next;
                out_count   <= w_cnt_next;
                out_sat     <= w_sat_next;
                out_cnt_ovf <= w_cnt_ovf_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_vector_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mac_vector_engine
// Brief    : Directed self-checking bench for mac_vector_engine.
// Revision : 1.0
// ============================================================================
module tb_mac_vector_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_a;
    logic signed [7:0] in_b;
    logic signed [7:0] in_add;
    logic              in_last;
    logic              in_mode;
    logic              out_valid;
    logic              out_ready;
    logic signed [24:0] out_data;
    logic [7:0]        out_count;
    logic              out_sat;
    logic              out_cnt_ovf;

    logic              s_in_ready, s_out_valid, s_out_sat, s_out_cnt_ovf;
    logic signed [16:0] s_out_data;
    logic [1:0]        s_out_count;
    logic              w_in_ready, w_out_valid, w_out_sat, w_out_cnt_ovf;
    logic signed [16:0] w_out_data;
    logic [1:0]        w_out_count;

    int n_checks = 0;
    int n_errors = 0;

    longint q_data[$];
    longint q_count[$];

    mac_vector_engine dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_add(in_add), .in_last(in_last), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_sat(out_sat), .out_cnt_ovf(out_cnt_ovf)
    );

    mac_vector_engine #(.DATA_W(8), .ACC_W(17), .CNT_W(2), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_add(in_add), .in_last(in_last), .in_mode(in_mode),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_count(s_out_count), .out_sat(s_out_sat), .out_cnt_ovf(s_out_cnt_ovf)
    );

    mac_vector_engine #(.DATA_W(8), .ACC_W(17), .CNT_W(2), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_a(in_a), .in_b(in_b), .in_add(in_add), .in_last(in_last), .in_mode(in_mode),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
        .out_count(w_out_count), .out_sat(w_out_sat), .out_cnt_ovf(w_out_cnt_ovf)
    );

    task automatic check_value(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            q_data.push_back(longint'(out_data));
            q_count.push_back(longint'(out_count));
        end
    end

    function automatic longint pop_data();
        if (q_data.size() == 0) return -64'sd999999;
        return q_data.pop_front();
    endfunction

    function automatic longint pop_count();
        if (q_count.size() == 0) return -64'sd999999;
        return q_count.pop_front();
    endfunction

    task automatic set_beat(input int a, input int b, input int add, input bit last, input bit mode);
        in_a    = a[7:0];
        in_b    = b[7:0];
        in_add  = add[7:0];
        in_last = last;
        in_mode = mode;
    endtask

    // Called just after a posedge; returns just after the edge that accepted the beat.
    task automatic drive_beat(input int a, input int b, input int add, input bit last, input bit mode);
        int guard;
        set_beat(a, b, add, last, mode);
        in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check_value("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input string tag);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) check_value(tag, 0, 1);
    endtask

    task automatic stall_three();
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        if (!out_valid) check_value("bp_result_timeout", 0, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("bp_in_ready_low", longint'(in_ready), 0);
            check_value("bp_hold_data", longint'(out_data), 6);
            check_value("bp_hold_valid", longint'(out_valid), 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_value("bp_in_ready_back", longint'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        out_ready = 1'b1;
        set_beat(-3, 5, 7, 1'b0, 1'b0);
        in_valid  = 1'b1;

        // Reset held with a beat offered
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_out_valid", longint'(out_valid), 0);
        check_value("rst_out_data", longint'(out_data), 0);
        check_value("rst_out_count", longint'(out_count), 0);
        check_value("rst_out_sat", longint'(out_sat), 0);
        check_value("rst_out_cnt_ovf", longint'(out_cnt_ovf), 0);
        check_value("rst_in_ready", longint'(in_ready), 0);

        // Single mode back-to-back
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_value("rel_in_ready", longint'(in_ready), 1);
        check_value("rel_out_valid", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        set_beat(4, 4, 0, 1'b0, 1'b0);
        @(negedge clk);
        check_value("lat_not_yet", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        set_beat(-128, -128, -128, 1'b0, 1'b0);
        @(negedge clk);
        check_value("single0_valid", longint'(out_valid), 1);
        check_value("single0_data", longint'(out_data), -8);
        check_value("single0_count", longint'(out_count), 1);
        @(posedge clk);
        #1;
        set_beat(127, -128, 0, 1'b0, 1'b0);
        @(negedge clk);
        check_value("single1_data", longint'(out_data), 16);
        check_value("single1_count", longint'(out_count), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_value("single2_data", longint'(out_data), 16256);
        check_value("single2_valid", longint'(out_valid), 1);
        @(posedge clk);
        @(negedge clk);
        check_value("single3_data", longint'(out_data), -16256);
        check_value("single3_count", longint'(out_count), 1);
        @(posedge clk);
        @(negedge clk);
        check_value("single_drained", longint'(out_valid), 0);

        // Dot mode, then an immediate second vector whose later beats flip in_mode
        @(posedge clk);
        #1;
        q_data.delete();
        q_count.delete();
        drive_beat(1, 5, 10, 1'b0, 1'b1);
        drive_beat(2, 6, 99, 1'b0, 1'b1);
        drive_beat(3, 7, 99, 1'b0, 1'b1);
        drive_beat(4, 8, 99, 1'b1, 1'b1);
        drive_beat(-1, 2, -5, 1'b0, 1'b1);
        drive_beat(3, -4, 99, 1'b0, 1'b0);
        drive_beat(2, 2, 99, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check_value("dot_results", longint'(q_data.size()), 2);
        check_value("dot0_data", pop_data(), 80);
        check_value("dot0_count", pop_count(), 4);
        check_value("dot1_data", pop_data(), -15);
        check_value("dot1_count", pop_count(), 3);

        // Backpressure across two 3-beat vectors
        fork
            begin
                drive_beat(1, 1, 0, 1'b0, 1'b1);
                drive_beat(2, 1, 0, 1'b0, 1'b1);
                drive_beat(3, 1, 0, 1'b1, 1'b1);
                drive_beat(-2, 3, 100, 1'b0, 1'b1);
                drive_beat(5, 3, 0, 1'b0, 1'b1);
                drive_beat(7, -1, 0, 1'b1, 1'b1);
            end
            stall_three();
        join
        repeat (6) @(posedge clk);
        #1;
        check_value("bp_results", longint'(q_data.size()), 2);
        check_value("bp0_data", pop_data(), 6);
        check_value("bp0_count", pop_count(), 3);
        check_value("bp1_data", pop_data(), 102);
        check_value("bp1_count", pop_count(), 3);

        // Overflow on the narrow instances
        for (int i = 0; i < 4; i++) begin
            drive_beat(-128, -128, 0, (i == 3), 1'b1);
        end
        wait_out_valid("sat_timeout");
        check_value("sat_data", longint'(s_out_data), 65535);
        check_value("sat_flag", longint'(s_out_sat), 1);
        check_value("sat_count", longint'(s_out_count), 3);
        check_value("sat_cnt_ovf", longint'(s_out_cnt_ovf), 1);
        check_value("wrap_data", longint'(w_out_data), -65536);
        check_value("wrap_flag", longint'(w_out_sat), 1);
        check_value("wide_data", longint'(out_data), 65536);
        check_value("wide_sat", longint'(out_sat), 0);
        check_value("wide_count", longint'(out_count), 4);

        // Reset in the middle of a dot vector
        @(posedge clk);
        #1;
        drive_beat(5, 5, 50, 1'b0, 1'b1);
        drive_beat(6, 6, 0, 1'b0, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check_value("mid_rst_valid", longint'(out_valid), 0);
        check_value("mid_rst_data", longint'(out_data), 0);
        check_value("mid_rst_in_ready", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_beat(2, 3, 1, 1'b0, 1'b1);
        drive_beat(3, 3, 0, 1'b1, 1'b1);
        wait_out_valid("post_rst_timeout");
        check_value("post_rst_data", longint'(out_data), 16);
        check_value("post_rst_count", longint'(out_count), 2);
        check_value("post_rst_sat", longint'(out_sat), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
